sram_1r1w_pipe: RTL



---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_resp_queue.sv | 32 +++
 rtl/sram_1r1w_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared state type, response-queue depth and byte-lane merge for sram_1r1w_pipe.
package sram_pkg;
   typedef enum logic {SRAM_INIT, SRAM_RUN} sram_state_e;
   localparam int c_resp_q_depth = 2;
   localparam int c_max_nbits = 512;
   function automatic logic [c_max_nbits-1:0] byte_merge(
      input logic [c_max_nbits-1:0]   old_word,
      input logic [c_max_nbits-1:0]   new_word,
      input logic [c_max_nbits/8-1:0] byte_en
   );
      logic [c_max_nbits-1:0] m;
      for (int i = 0; i < c_max_nbits; i++) m[i] = byte_en[i/8] ? new_word[i] : old_word[i];
      return m;
   endfunction
endpackage

// File: rtl/sram_resp_queue.sv
// sram_resp_queue: 2-entry bypassable valid/ready queue; data passes straight through when empty and the consumer is ready.
module sram_resp_queue import sram_pkg::*; #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enq_val,
   input  logic [p_nbits-1:0] enq_data,
   output logic               deq_val,
   input  logic               deq_rdy,
   output logic [p_nbits-1:0] deq_data,
   output logic [1:0]         count
);
   logic [p_nbits-1:0] ent [c_resp_q_depth];
   logic head, empty, push, pop;
   assign empty = count == 2'd0;
   assign pop = deq_rdy && !empty;
   assign push = enq_val && !(empty && deq_rdy) && (count != 2'(c_resp_q_depth) || pop);
   assign deq_val = !empty || enq_val;
   assign deq_data = empty ? enq_data : ent[head];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         count <= '0;
         head <= 1'b0;
      end else begin
         count <= count + 2'(push) - 2'(pop);
         head <= head ^ pop;
      end
   // tail slot is head offset by count; when full it reuses the slot being popped
   always_ff @(posedge clk)
      if (push) ent[head ^ count[0]] <= enq_data;
endmodule

// File: rtl/sram_1r1w_pipe.sv
// sram_1r1w_pipe: 1R1W byte-enabled SRAM, write-first, valid/ready ports, 2-entry read response queue.
// Define SRAM_1R1W_CLEAR_EN to zero the whole array during INIT after reset.
module sram_1r1w_pipe import sram_pkg::*; #(
   parameter  int p_data_nbits  = 32,
   parameter  int p_num_entries = 64,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     rd_req_val,
   output logic                     rd_req_rdy,
   input  logic [c_addr_nbits-1:0]  rd_req_addr,
   output logic                     rd_resp_val,
   input  logic                     rd_resp_rdy,
   output logic [p_data_nbits-1:0]  rd_resp_data,
   input  logic                     wr_req_val,
   output logic                     wr_req_rdy,
   input  logic [c_addr_nbits-1:0]  wr_req_addr,
   input  logic [c_data_nbytes-1:0] wr_req_byte_en,
   input  logic [p_data_nbits-1:0]  wr_req_data
);
   localparam logic [c_addr_nbits:0] c_lim = (c_addr_nbits+1)'(p_num_entries);
   sram_state_e state, state_n;
   logic [p_data_nbits-1:0] mem [p_num_entries];
   logic [p_data_nbits-1:0] s1_data, wr_word, rd_word;
   logic [c_addr_nbits-1:0] clr_cnt;
   logic [1:0] q_count;
   logic s1_val, rd_fire, wr_fire, rd_ok, wr_ok, clr_we;
   assign rd_fire = rd_req_val && rd_req_rdy;
   assign wr_fire = wr_req_val && wr_req_rdy;
   assign rd_ok = {1'b0, rd_req_addr} < c_lim;
   assign wr_ok = {1'b0, wr_req_addr} < c_lim;
   assign wr_word = p_data_nbits'(byte_merge(c_max_nbits'(mem[wr_req_addr]), c_max_nbits'(wr_req_data),
                                             (c_max_nbits/8)'(wr_req_byte_en)));
   // write-first: a same-cycle write to the read address forwards the merged word
   assign rd_word = !rd_ok ? '0 : (wr_fire && wr_ok && wr_req_addr == rd_req_addr) ? wr_word : mem[rd_req_addr];
`ifdef SRAM_1R1W_CLEAR_EN
   localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) clr_cnt <= '0;
      else if (clr_we) clr_cnt <= clr_cnt + c_addr_nbits'(1);
`else
   assign clr_cnt = '0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= SRAM_INIT;
      else state <= state_n;
   always_comb begin
      state_n = state;
      clr_we = 1'b0;
      rd_req_rdy = 1'b0;
      wr_req_rdy = 1'b0;
      if (state == SRAM_INIT) begin
`ifdef SRAM_1R1W_CLEAR_EN
         clr_we = 1'b1;
         state_n = clr_cnt == c_last ? SRAM_RUN : SRAM_INIT;
`else
         state_n = SRAM_RUN;
`endif
      end else begin
         wr_req_rdy = 1'b1;
         rd_req_rdy = ({1'b0, q_count} + {2'b00, s1_val}) < 3'(c_resp_q_depth);
      end
   end
   always_ff @(posedge clk)
      if (clr_we) mem[clr_cnt] <= '0;
      else if (wr_fire && wr_ok) mem[wr_req_addr] <= wr_word;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1_val <= 1'b0;
         s1_data <= '0;
      end else begin
         s1_val <= rd_fire;
         if (rd_fire) s1_data <= rd_word;
      end
   sram_resp_queue #(.p_nbits(p_data_nbits)) u_resp_q (
      .clk      (clk),
      .reset_n  (reset_n),
      .enq_val  (s1_val),
      .enq_data (s1_data),
      .deq_val  (rd_resp_val),
      .deq_rdy  (rd_resp_rdy),
      .deq_data (rd_resp_data),
      .count    (q_count)
   );
endmodule
